// File: rtl/inst_mem_responder_if.sv
// Fetch-side request/response bus plus the program-load write port.
// slave: the memory responder; master: instruction fetch / boot loader.
interface inst_mem_responder_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  req_valid_i;
    logic [31:0]           req_pc_i;
    logic                  req_ready_o;
    logic                  flush_i;
    logic                  resp_valid_o;
    logic [31:0]           resp_inst_o;
    logic [31:0]           resp_pc_o;
    logic                  resp_err_o;
    logic                  resp_ready_i;
    logic                  load_we_i;
    logic [ADDR_WIDTH-1:0] load_addr_i;
    logic [31:0]           load_data_i;

    modport slave (
        input  req_valid_i, req_pc_i, flush_i, resp_ready_i,
               load_we_i, load_addr_i, load_data_i,
        output req_ready_o, resp_valid_o, resp_inst_o, resp_pc_o, resp_err_o
    );

    modport master (
        output req_valid_i, req_pc_i, flush_i, resp_ready_i,
               load_we_i, load_addr_i, load_data_i,
        input  req_ready_o, resp_valid_o, resp_inst_o, resp_pc_o, resp_err_o
    );
endinterface

// File: rtl/inst_mem_responder.sv
// Pipelined instruction memory answering fetch PCs with word, PC and error flag.
// Latency: LATENCY cycles from acceptance to resp_valid_o (1..4), one request per cycle.
// Backpressure: resp_ready_i low freezes every stage; flush/load block acceptance.
module inst_mem_responder #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                clk_i,
    input  logic                reset_i,
    inst_mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    err_q;
    logic [31:0]           pc_q   [LATENCY];
    logic [31:0]           inst_q [LATENCY];

    logic                  stall;
    logic                  accept;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign stall           = bus.resp_valid_o & ~bus.resp_ready_i;
    assign bus.req_ready_o = ~stall & ~bus.flush_i & ~bus.load_we_i;
    assign accept          = bus.req_valid_i & bus.req_ready_o;

    assign req_err = (bus.req_pc_i[1:0] != 2'b00) |
                     (bus.req_pc_i[31:ADDR_WIDTH+2] != '0);
    assign rd_idx  = bus.req_pc_i[ADDR_WIDTH+1:2];

    // Boot-load writes never coincide with a read: acceptance is blocked while load_we_i is high.
    always_ff @(posedge clk_i) begin
        if (bus.load_we_i) begin
            mem[bus.load_addr_i] <= bus.load_data_i;
        end
    end

    // Stage 0 is the synchronous read register; it only loads on acceptance,
    // so a stall or a load cycle leaves the captured word untouched.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (bus.flush_i) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q[0] <= accept;
            if (accept) begin
                pc_q[0]   <= bus.req_pc_i;
                err_q[0]  <= req_err;
                inst_q[0] <= req_err ? NOP_INST : mem[rd_idx];
            end
            // Data only moves with a valid beat so the outputs hold their last values when idle.
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    pc_q[i]   <= pc_q[i-1];
                    err_q[i]  <= err_q[i-1];
                    inst_q[i] <= inst_q[i-1];
                end
            end
        end
    end

    assign bus.resp_valid_o = vld_q[LATENCY-1];
    assign bus.resp_inst_o  = inst_q[LATENCY-1];
    assign bus.resp_pc_o    = pc_q[LATENCY-1];
    assign bus.resp_err_o   = err_q[LATENCY-1];
endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench: three responders (LATENCY 1, 2, 4) share one stimulus stream;
// a vector table drives the LATENCY=2 instance, hand sequences cover sweep, flush and reset.
module tb_inst_mem_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    inst_mem_responder_if #(.ADDR_WIDTH(14)) if1 ();
    inst_mem_responder_if #(.ADDR_WIDTH(14)) if2 ();
    inst_mem_responder_if #(.ADDR_WIDTH(14)) if4 ();

    inst_mem_responder #(.ADDR_WIDTH(14), .LATENCY(1)) dut1 (.clk_i(clk), .reset_i(rst_n), .bus(if1));
    inst_mem_responder #(.ADDR_WIDTH(14), .LATENCY(2)) dut2 (.clk_i(clk), .reset_i(rst_n), .bus(if2));
    inst_mem_responder #(.ADDR_WIDTH(14), .LATENCY(4)) dut4 (.clk_i(clk), .reset_i(rst_n), .bus(if4));

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        rr;
        logic        fl;
        logic        lw;
        logic [13:0] la;
        logic [31:0] ld;
        logic        erdy;
        logic        evld;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        eerr;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] words[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] pc, input logic rr, input logic fl,
                         input logic lw, input logic [13:0] la, input logic [31:0] ld);
        if1.req_valid_i = rv; if1.req_pc_i = pc; if1.resp_ready_i = rr; if1.flush_i = fl;
        if1.load_we_i = lw; if1.load_addr_i = la; if1.load_data_i = ld;
        if2.req_valid_i = rv; if2.req_pc_i = pc; if2.resp_ready_i = rr; if2.flush_i = fl;
        if2.load_we_i = lw; if2.load_addr_i = la; if2.load_data_i = ld;
        if4.req_valid_i = rv; if4.req_pc_i = pc; if4.resp_ready_i = rr; if4.flush_i = fl;
        if4.load_we_i = lw; if4.load_addr_i = la; if4.load_data_i = ld;
    endtask

    function automatic void row(logic rv, logic [31:0] pc, logic rr, logic fl, logic lw,
                                logic [13:0] la, logic [31:0] ld, logic erdy, logic evld,
                                logic [31:0] epc, logic [31:0] einst, logic eerr);
        vec_t v;
        v.rv = rv; v.pc = pc; v.rr = rr; v.fl = fl; v.lw = lw; v.la = la; v.ld = ld;
        v.erdy = erdy; v.evld = evld; v.epc = epc; v.einst = einst; v.eerr = eerr;
        vecs.push_back(v);
    endfunction

    function automatic void ld(logic [13:0] a, logic [31:0] d);
        row(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, a, d, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endfunction

    function automatic void rq(logic rv, logic [31:0] pc, logic rr, logic fl, logic erdy,
                               logic evld, logic [31:0] epc, logic [31:0] einst, logic eerr);
        row(rv, pc, rr, fl, 1'b0, 14'h0, 32'h0, erdy, evld, epc, einst, eerr);
    endfunction

    task automatic chk_zero(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic err);
        chk({tag, "_vld"}, {31'h0, v}, 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_err"}, {31'h0, err}, 32'h0);
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        words[0] = 32'h00500093; words[1] = 32'h00100113;
        words[2] = 32'h002081B3; words[3] = 32'h00000013;

        // Program load, including word 16 (PC 0x40) and the last word (PC 0xFFFC).
        ld(14'd0, words[0]); ld(14'd1, words[1]); ld(14'd2, words[2]); ld(14'd3, words[3]);
        ld(14'd16, 32'hAAAA0001); ld(14'd16383, 32'h12345678);
        // Back-to-back fetch.
        rq(1, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(1, 32'h4, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(1, 32'h8, 1, 0, 1, 1, 32'h0, words[0], 0);
        rq(1, 32'hC, 1, 0, 1, 1, 32'h4, words[1], 0);
        rq(0, 32'h0, 1, 0, 1, 1, 32'h8, words[2], 0);
        rq(0, 32'h0, 1, 0, 1, 1, 32'hC, words[3], 0);
        rq(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        // Stall for three cycles with PC 4 at the output.
        rq(1, 32'h4, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(1, 32'h8, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(1, 32'hC, 0, 0, 0, 1, 32'h4, words[1], 0);
        rq(1, 32'hC, 0, 0, 0, 1, 32'h4, words[1], 0);
        rq(1, 32'hC, 0, 0, 0, 1, 32'h4, words[1], 0);
        rq(1, 32'hC, 1, 0, 1, 1, 32'h4, words[1], 0);
        rq(0, 32'h0, 1, 0, 1, 1, 32'h8, words[2], 0);
        rq(0, 32'h0, 1, 0, 1, 1, 32'hC, words[3], 0);
        rq(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        // Flush drops PC 8 (in flight) and PC C (offered during flush).
        rq(1, 32'h8, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(1, 32'hC, 1, 1, 0, 0, 32'h0, 32'h0, 0);
        rq(1, 32'h40, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(0, 32'h0, 1, 0, 1, 1, 32'h40, 32'hAAAA0001, 0);
        rq(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        // Misaligned, out of range, and the last in-range word.
        rq(1, 32'h2, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(1, 32'h10000, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(1, 32'hFFFC, 1, 0, 1, 1, 32'h2, 32'h00000013, 1);
        rq(0, 32'h0, 1, 0, 1, 1, 32'h10000, 32'h00000013, 1);
        rq(0, 32'h0, 1, 0, 1, 1, 32'hFFFC, 32'h12345678, 0);
        rq(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        // Load blocks fetch, then the new word is read back.
        row(1, 32'h14, 1, 0, 1, 14'd5, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 0);
        rq(1, 32'h14, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);
        rq(0, 32'h0, 1, 0, 1, 1, 32'h14, 32'hDEADBEEF, 0);
        rq(0, 32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 0);

        drive(0, 32'h0, 1, 0, 0, 14'h0, 32'h0);
        rst_n = 1'b0;
        #2;
        chk_zero("rst_l1", if1.resp_valid_o, if1.resp_inst_o, if1.resp_pc_o, if1.resp_err_o);
        chk_zero("rst_l2", if2.resp_valid_o, if2.resp_inst_o, if2.resp_pc_o, if2.resp_err_o);
        chk_zero("rst_l4", if4.resp_valid_o, if4.resp_inst_o, if4.resp_pc_o, if4.resp_err_o);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rv, vecs[k].pc, vecs[k].rr, vecs[k].fl, vecs[k].lw, vecs[k].la, vecs[k].ld);
            #2;
            chk($sformatf("v%0d_rdy", k), {31'h0, if2.req_ready_o}, {31'h0, vecs[k].erdy});
            chk($sformatf("v%0d_vld", k), {31'h0, if2.resp_valid_o}, {31'h0, vecs[k].evld});
            if (vecs[k].evld) begin
                chk($sformatf("v%0d_inst", k), if2.resp_inst_o, vecs[k].einst);
                chk($sformatf("v%0d_pc", k), if2.resp_pc_o, vecs[k].epc);
                chk($sformatf("v%0d_err", k), {31'h0, if2.resp_err_o}, {31'h0, vecs[k].eerr});
            end
        end

        repeat (5) begin
            @(negedge clk);
            drive(0, 32'h0, 1, 0, 0, 14'h0, 32'h0);
        end

        // Latency sweep: the same four-request burst seen by all three depths.
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            drive(t < 4, 32'(4 * t), 1, 0, 0, 14'h0, 32'h0);
            #2;
            chk($sformatf("sw_l1_vld%0d", t), {31'h0, if1.resp_valid_o}, {31'h0, (t >= 1 && t <= 4)});
            chk($sformatf("sw_l2_vld%0d", t), {31'h0, if2.resp_valid_o}, {31'h0, (t >= 2 && t <= 5)});
            chk($sformatf("sw_l4_vld%0d", t), {31'h0, if4.resp_valid_o}, {31'h0, (t >= 4 && t <= 7)});
            if (t >= 1 && t <= 4) begin
                chk($sformatf("sw_l1_pc%0d", t), if1.resp_pc_o, 32'(4 * (t - 1)));
                chk($sformatf("sw_l1_inst%0d", t), if1.resp_inst_o, words[t-1]);
            end
            if (t >= 4 && t <= 7) begin
                chk($sformatf("sw_l4_pc%0d", t), if4.resp_pc_o, 32'(4 * (t - 4)));
                chk($sformatf("sw_l4_inst%0d", t), if4.resp_inst_o, words[t-4]);
            end
        end

        // Deep pipeline: PCs 8 and C both in flight when the flush lands.
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            case (t)
                0:       drive(1, 32'h8, 1, 0, 0, 14'h0, 32'h0);
                1:       drive(1, 32'hC, 1, 0, 0, 14'h0, 32'h0);
                2:       drive(1, 32'h40, 1, 1, 0, 14'h0, 32'h0);
                3:       drive(1, 32'h40, 1, 0, 0, 14'h0, 32'h0);
                default: drive(0, 32'h0, 1, 0, 0, 14'h0, 32'h0);
            endcase
            #2;
            if (t == 2) chk("fl4_rdy", {31'h0, if4.req_ready_o}, 32'h0);
            chk($sformatf("fl4_vld%0d", t), {31'h0, if4.resp_valid_o}, {31'h0, (t == 7)});
            if (t == 7) begin
                chk("fl4_pc", if4.resp_pc_o, 32'h40);
                chk("fl4_inst", if4.resp_inst_o, 32'hAAAA0001);
            end
        end

        // Reset mid-stream, asserted between clock edges.
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            drive(1, 32'(4 * t), 1, 0, 0, 14'h0, 32'h0);
        end
        #2;
        chk("mr_pre_vld", {31'h0, if2.resp_valid_o}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("mr_l2", if2.resp_valid_o, if2.resp_inst_o, if2.resp_pc_o, if2.resp_err_o);
        chk("mr_l1_vld", {31'h0, if1.resp_valid_o}, 32'h0);
        chk("mr_l4_vld", {31'h0, if4.resp_valid_o}, 32'h0);
        drive(0, 32'h0, 1, 0, 0, 14'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            drive(t == 0, 32'h0, 1, 0, 0, 14'h0, 32'h0);
            #2;
            chk($sformatf("pr_l1_vld%0d", t), {31'h0, if1.resp_valid_o}, {31'h0, (t == 1)});
            chk($sformatf("pr_l4_vld%0d", t), {31'h0, if4.resp_valid_o}, {31'h0, (t == 4)});
            chk($sformatf("pr_l2_vld%0d", t), {31'h0, if2.resp_valid_o}, {31'h0, (t == 2)});
            if (t == 2) chk("pr_l2_inst", if2.resp_inst_o, words[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
